// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants and types used by rename, issue and
// the writeback arbiter.
package ooo_pkg;
  localparam int NUM_PREG = 64;
  localparam int PREG_W   = 6;
  localparam int DATA_W   = 32;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic  en;
    preg_t preg;
    data_t data;
  } wr_port_t;
endpackage

// File: rtl/phys_wb_arbiter_if.sv
// Writeback bundle: requester valid/ready handshake plus the two register
// file write ports.
interface phys_wb_arbiter_if import ooo_pkg::*; #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]             req_valid;
  preg_t [NUM_REQ-1:0]            req_preg;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;

  preg_t                          reg_to_update1;
  data_t                          new_value1;
  logic                           update1;
  preg_t                          reg_to_update2;
  data_t                          new_value2;
  logic                           update2;

  modport master (
    output req_valid, req_preg, req_data,
    input  req_ready,
    input  reg_to_update1, new_value1, update1,
    input  reg_to_update2, new_value2, update2
  );

  modport slave (
    input  req_valid, req_preg, req_data,
    output req_ready,
    output reg_to_update1, new_value1, update1,
    output reg_to_update2, new_value2, update2
  );
endinterface

// File: rtl/phys_wb_arbiter_rr_pick2.sv
// Combinational rotating picker: up to two grants per cycle starting at ptr,
// never granting two requests for the same destination register.
module rr_pick2 import ooo_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  preg_t [NUM_REQ-1:0] preg,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               g1_vld,
  output logic [PTR_W-1:0]   g1_idx,
  output logic               g2_vld,
  output logic [PTR_W-1:0]   g2_idx
);
  int               j;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant  = '0;
    g1_vld = 1'b0;
    g1_idx = '0;
    g2_vld = 1'b0;
    g2_idx = '0;
    j      = 0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = PTR_W'(j);
      if (valid[idx]) begin
        if (!g1_vld) begin
          g1_vld     = 1'b1;
          g1_idx     = idx;
          grant[idx] = 1'b1;
        end else if (!g2_vld && (preg[idx] != preg[g1_idx])) begin
          // a same-register loser stays pending; the scan keeps looking
          g2_vld     = 1'b1;
          g2_idx     = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/phys_wb_arbiter.sv
// Writeback arbiter for the physical register file: two registered write
// ports fed round-robin from NUM_REQ units, plus the per-register ready bits.
module phys_wb_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_PREG = ooo_pkg::NUM_PREG,
  parameter int PREG_W   = ooo_pkg::PREG_W,
  parameter int DATA_W   = ooo_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  phys_wb_arbiter_if.slave    bus,
  input  logic                alloc_valid,
  input  logic [PREG_W-1:0]   alloc_preg,
  output logic [NUM_PREG-1:0] preg_ready
);
  import ooo_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   last_idx;
  logic [NUM_REQ-1:0] grant;
  logic               g1_vld, g2_vld;
  logic [PTR_W-1:0]   g1_idx, g2_idx;
  logic               act, w1, w2;

  logic               upd1_q, upd2_q;
  logic [PREG_W-1:0]  idx1_q, idx2_q;
  logic [DATA_W-1:0]  dat1_q, dat2_q;

  logic [NUM_PREG-1:0] sb_set, sb_clr;

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid  (bus.req_valid),
    .preg   (bus.req_preg),
    .ptr    (rr_ptr),
    .grant  (grant),
    .g1_vld (g1_vld),
    .g1_idx (g1_idx),
    .g2_vld (g2_vld),
    .g2_idx (g2_idx)
  );

  assign act           = !reset && !stall;
  assign w1            = act && g1_vld;
  assign w2            = act && g2_vld;
  assign bus.req_ready = act ? grant : '0;
  assign last_idx      = g2_vld ? g2_idx : g1_idx;

  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (w1)
      rr_ptr <= (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
  end

  // Ports are registered so the file sees a full-cycle-stable value at its
  // negedge write; stall holds the whole port so the write completes later.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd1_q <= 1'b0;
      upd2_q <= 1'b0;
      idx1_q <= '0;
      idx2_q <= '0;
      dat1_q <= '0;
      dat2_q <= '0;
    end else if (!stall) begin
      upd1_q <= g1_vld;
      upd2_q <= g2_vld;
      if (g1_vld) begin
        idx1_q <= bus.req_preg[g1_idx];
        dat1_q <= bus.req_data[g1_idx];
      end
      if (g2_vld) begin
        idx2_q <= bus.req_preg[g2_idx];
        dat2_q <= bus.req_data[g2_idx];
      end
    end
  end

  assign bus.update1        = upd1_q;
  assign bus.reg_to_update1 = idx1_q;
  assign bus.new_value1     = dat1_q;
  assign bus.update2        = upd2_q;
  assign bus.reg_to_update2 = idx2_q;
  assign bus.new_value2     = dat2_q;

  for (genvar p = 0; p < NUM_PREG; p++) begin : g_sb
    assign sb_clr[p] = alloc_valid && (alloc_preg == PREG_W'(p));
    assign sb_set[p] = (w1 && (bus.req_preg[g1_idx] == PREG_W'(p))) ||
                       (w2 && (bus.req_preg[g2_idx] == PREG_W'(p)));
  end

  // a rename allocation in the same edge as a writeback wins: the register
  // now belongs to a new, not-yet-produced value
  always_ff @(posedge clk) begin
    if (reset) preg_ready <= '1;
    else       preg_ready <= (preg_ready | sb_set) & ~sb_clr;
  end
endmodule

// File: tb/tb_phys_wb_arbiter.sv
// Bench for phys_wb_arbiter: hand-derived vector table, reset sequence and a
// randomized run against a rule-level reference model.
module tb_phys_wb_arbiter;
  import ooo_pkg::*;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                reset, stall, alloc_valid;
  preg_t               alloc_preg;
  logic [NUM_PREG-1:0] preg_ready;

  always #5 clk = ~clk;

  phys_wb_arbiter_if #(.NUM_REQ(N)) bus();

  phys_wb_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .bus         (bus),
    .alloc_valid (alloc_valid),
    .alloc_preg  (alloc_preg),
    .preg_ready  (preg_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model state
  int          m_ptr;
  bit [63:0]   m_pr;
  bit          m_u1, m_u2;
  preg_t       m_p1, m_p2;
  data_t       m_d1, m_d2;

  // One clock: check req_ready before the edge, advance the model, check the
  // registered outputs and scoreboard after the edge.
  task automatic cycle(output logic [N-1:0] rdy_s);
    int          order[$];
    int          g1, g2, o;
    logic [N-1:0] er;
    bit [63:0]   pr_n;
    g1 = -1; g2 = -1; er = '0;
    if (!reset && !stall) begin
      for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
      foreach (order[k]) begin
        o = order[k];
        if (bus.req_valid[o]) begin
          if (g1 < 0) g1 = o;
          else if (g2 < 0 && bus.req_preg[o] != bus.req_preg[g1]) g2 = o;
        end
      end
    end
    if (g1 >= 0) er[g1] = 1'b1;
    if (g2 >= 0) er[g2] = 1'b1;
    #1;
    rdy_s = bus.req_ready;
    chk("req_ready", {60'd0, rdy_s}, {60'd0, er});
    if (reset) begin
      m_ptr = 0; m_pr = '1;
      m_u1 = 0; m_p1 = '0; m_d1 = '0;
      m_u2 = 0; m_p2 = '0; m_d2 = '0;
    end else begin
      pr_n = m_pr;
      if (!stall) begin
        m_u1 = (g1 >= 0);
        m_u2 = (g2 >= 0);
        if (g1 >= 0) begin m_p1 = bus.req_preg[g1]; m_d1 = bus.req_data[g1]; pr_n[m_p1] = 1'b1; end
        if (g2 >= 0) begin m_p2 = bus.req_preg[g2]; m_d2 = bus.req_data[g2]; pr_n[m_p2] = 1'b1; end
        if (g1 >= 0) m_ptr = (((g2 >= 0) ? g2 : g1) + 1) % N;
      end
      if (alloc_valid) pr_n[alloc_preg] = 1'b0;
      m_pr = pr_n;
    end
    @(posedge clk);
    #1;
    chk("update1", {63'd0, bus.update1}, {63'd0, m_u1});
    chk("reg1", {58'd0, bus.reg_to_update1}, {58'd0, m_p1});
    chk("value1", {32'd0, bus.new_value1}, {32'd0, m_d1});
    chk("update2", {63'd0, bus.update2}, {63'd0, m_u2});
    chk("reg2", {58'd0, bus.reg_to_update2}, {58'd0, m_p2});
    chk("value2", {32'd0, bus.new_value2}, {32'd0, m_d2});
    chk("preg_ready", preg_ready, m_pr);
  endtask

  typedef struct {
    logic         stl;
    logic         av;
    preg_t        ap;
    logic [N-1:0] v;
    preg_t        p[N];
    data_t        d[N];
    logic [N-1:0] er;
    logic         eu1;
    preg_t        ep1;
    logic         eu2;
    preg_t        ep2;
    int           cp;
    logic         epr;
  } vec_t;

  vec_t tbl[15];

  task automatic drive(input logic stl, input logic av, input preg_t ap, input logic [N-1:0] v,
                       input preg_t p[N], input data_t d[N]);
    stall = stl; alloc_valid = av; alloc_preg = ap;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = v[i];
      bus.req_preg[i]  = p[i];
      bus.req_data[i]  = d[i];
    end
  endtask

  logic [N-1:0] rs;
  bit           pv[N];
  preg_t        pp[N];
  data_t        pd[N];
  preg_t        hp[N];
  data_t        hd[N];

  initial begin
    //            stl av ap  v        p                d                                er       eu1 ep1 eu2 ep2 cp  epr
    tbl[0]  = '{0, 0, 0,  4'b0000, '{0,0,0,0},      '{0,0,0,0},                      4'b0000, 0, 0,  0, 0,  5,  1};
    tbl[1]  = '{0, 0, 0,  4'b0101, '{5,0,9,0},      '{32'hAAAA,0,32'hBBBB,0},        4'b0101, 1, 5,  1, 9,  9,  1};
    tbl[2]  = '{0, 0, 0,  4'b1000, '{0,0,0,20},     '{0,0,0,32'h2020},               4'b1000, 1, 20, 0, 0,  20, 1};
    tbl[3]  = '{0, 0, 0,  4'b1111, '{1,2,3,4},      '{32'h11,32'h12,32'h13,32'h14},  4'b0011, 1, 1,  1, 2,  1,  1};
    tbl[4]  = '{0, 0, 0,  4'b1111, '{1,2,3,4},      '{32'h21,32'h22,32'h23,32'h24},  4'b1100, 1, 3,  1, 4,  3,  1};
    tbl[5]  = '{0, 0, 0,  4'b1111, '{1,2,3,4},      '{32'h31,32'h32,32'h33,32'h34},  4'b0011, 1, 1,  1, 2,  2,  1};
    tbl[6]  = '{0, 1, 7,  4'b0100, '{0,0,30,0},     '{0,0,32'h3030,0},               4'b0100, 1, 30, 0, 0,  7,  0};
    tbl[7]  = '{0, 0, 0,  4'b1000, '{0,0,0,31},     '{0,0,0,32'h3131},               4'b1000, 1, 31, 0, 0,  7,  0};
    tbl[8]  = '{0, 0, 0,  4'b1010, '{0,7,0,7},      '{0,32'h71,0,32'h73},            4'b0010, 1, 7,  0, 0,  7,  1};
    tbl[9]  = '{0, 0, 0,  4'b1000, '{0,0,0,7},      '{0,0,0,32'h73},                 4'b1000, 1, 7,  0, 0,  7,  1};
    tbl[10] = '{1, 0, 0,  4'b0011, '{40,41,0,0},    '{32'h40,32'h41,0,0},            4'b0000, 1, 7,  0, 0,  40, 1};
    tbl[11] = '{1, 1, 41, 4'b0011, '{40,41,0,0},    '{32'h40,32'h41,0,0},            4'b0000, 1, 7,  0, 0,  41, 0};
    tbl[12] = '{0, 0, 0,  4'b0011, '{40,41,0,0},    '{32'h40,32'h41,0,0},            4'b0011, 1, 40, 1, 41, 41, 1};
    tbl[13] = '{0, 1, 12, 4'b0100, '{0,0,12,0},     '{0,0,32'h1212,0},               4'b0100, 1, 12, 0, 0,  12, 0};
    tbl[14] = '{0, 0, 0,  4'b0000, '{0,0,0,0},      '{0,0,0,0},                      4'b0000, 0, 0,  0, 0,  12, 0};

    // reset with requests present: nothing may be accepted
    reset = 1'b1; stall = 1'b0; alloc_valid = 1'b0; alloc_preg = '0;
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) begin bus.req_preg[i] = preg_t'(i + 1); bus.req_data[i] = 32'hDEAD; end
    @(posedge clk); #1;
    cycle(rs);
    cycle(rs);
    chk("reset req_ready", {60'd0, rs}, 64'd0);
    chk("reset update1", {63'd0, bus.update1}, 64'd0);
    chk("reset update2", {63'd0, bus.update2}, 64'd0);
    chk("reset preg_ready", preg_ready, {64{1'b1}});
    reset = 1'b0;

    for (int t = 0; t < 15; t++) begin
      drive(tbl[t].stl, tbl[t].av, tbl[t].ap, tbl[t].v, tbl[t].p, tbl[t].d);
      cycle(rs);
      chk($sformatf("tbl%0d ready", t), {60'd0, rs}, {60'd0, tbl[t].er});
      chk($sformatf("tbl%0d update1", t), {63'd0, bus.update1}, {63'd0, tbl[t].eu1});
      if (tbl[t].eu1) chk($sformatf("tbl%0d reg1", t), {58'd0, bus.reg_to_update1}, {58'd0, tbl[t].ep1});
      chk($sformatf("tbl%0d update2", t), {63'd0, bus.update2}, {63'd0, tbl[t].eu2});
      if (tbl[t].eu2) chk($sformatf("tbl%0d reg2", t), {58'd0, bus.reg_to_update2}, {58'd0, tbl[t].ep2});
      chk($sformatf("tbl%0d preg_ready[%0d]", t, tbl[t].cp), {63'd0, preg_ready[tbl[t].cp]}, {63'd0, tbl[t].epr});
    end

    // mid-stream reset: a granted write is loaded, then reset drops it
    hp = '{50, 0, 0, 0}; hd = '{32'h5050, 0, 0, 0};
    drive(0, 0, 0, 4'b0001, hp, hd);
    cycle(rs);
    chk("pre-reset ready", {60'd0, rs}, 64'h1);
    chk("pre-reset update1", {63'd0, bus.update1}, 64'h1);
    chk("pre-reset reg1", {58'd0, bus.reg_to_update1}, 64'd50);
    hp = '{51, 0, 0, 0}; hd = '{32'h5151, 0, 0, 0};
    drive(0, 1, 33, 4'b0001, hp, hd);
    reset = 1'b1;
    cycle(rs);
    chk("midreset ready", {60'd0, rs}, 64'd0);
    chk("midreset update1", {63'd0, bus.update1}, 64'd0);
    chk("midreset update2", {63'd0, bus.update2}, 64'd0);
    chk("midreset reg1", {58'd0, bus.reg_to_update1}, 64'd0);
    chk("midreset preg_ready", preg_ready, {64{1'b1}});
    reset = 1'b0;
    hp = '{0, 60, 61, 0}; hd = '{0, 32'h6060, 32'h6161, 0};
    drive(0, 0, 0, 4'b0110, hp, hd);
    cycle(rs);
    chk("postreset ready", {60'd0, rs}, 64'h6);
    chk("postreset reg1", {58'd0, bus.reg_to_update1}, 64'd60);
    chk("postreset reg2", {58'd0, bus.reg_to_update2}, 64'd61);

    // randomized traffic with conflicts, stalls, allocations and resets
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    alloc_valid = 1'b0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          pp[i] = preg_t'($urandom_range(0, 15));
          pd[i] = $urandom;
        end
        bus.req_valid[i] = pv[i];
        bus.req_preg[i]  = pp[i];
        bus.req_data[i]  = pd[i];
      end
      stall       = ($urandom_range(0, 7) == 0);
      alloc_valid = ($urandom_range(0, 3) == 0);
      alloc_preg  = preg_t'($urandom_range(0, 15));
      reset       = ($urandom_range(0, 99) == 0);
      cycle(rs);
      for (int i = 0; i < N; i++) if (rs[i]) pv[i] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/phys_wb_arbiter.md
# phys_wb_arbiter

Writeback arbiter and ready scoreboard for the 64-entry physical register file. Collects result writebacks from `NUM_REQ` functional units over valid/ready handshakes and grants at most two per cycle, round-robin, onto the file's two write ports. It also maintains the per-register ready bits consumed by issue. It sits between the execute stage and the physical register file, and is the only driver of that file's write ports.

## Interface
Parameters:
- `NUM_REQ`, 4, number of writeback requesters (2..8)
- `NUM_PREG`, 64, physical registers
- `PREG_W`, 6, physical register index width
- `DATA_W`, 32, result width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  pipeline stall; freezes grants and write-port outputs
- `req_valid`  in  NUM_REQ  requester i has a result
- `req_preg`  in  NUM_REQ*PREG_W  destination of requester i, slice i
- `req_data`  in  NUM_REQ*DATA_W  result of requester i, slice i
- `req_ready`  out  NUM_REQ  request i accepted this cycle
- `reg_to_update1`  out  PREG_W  write port 1 index
- `new_value1`  out  DATA_W  write port 1 data
- `update1`  out  1  write port 1 enable
- `reg_to_update2`  out  PREG_W  write port 2 index
- `new_value2`  out  DATA_W  write port 2 data
- `update2`  out  1  write port 2 enable
- `alloc_valid`  in  1  rename allocated a destination register this cycle
- `alloc_preg`  in  PREG_W  register being allocated
- `preg_ready`  out  NUM_PREG  bit p set means register p holds its final value

## Operation
- A transfer occurs when `req_valid[i] && req_ready[i]`. A requester holds `req_preg`/`req_data` stable until the transfer completes.
- Picker:
  - Scans requesters starting at `rr_ptr`, wrapping modulo `NUM_REQ`.
  - The first valid requester goes to port 1. The next valid requester whose `req_preg` differs from port 1's goes to port 2.
  - A same-register conflict leaves the second requester waiting.
- `rr_ptr` becomes (index of last granted requester + 1) mod `NUM_REQ`. It is unchanged when nothing is granted or `stall` is high.
- `req_ready` is combinational from `req_valid`, `req_preg`, `rr_ptr` and `stall`. It is all zero while `stall` is high.
- Write-port outputs are registered:
  - A grant in cycle N appears on the port in cycle N+1, so it is stable for the file's negedge write.
  - With no grant, `update1`/`update2` are 0 in N+1. Index and data hold their last values.
- While `stall` is high, all write-port output registers hold. The file ignores writes during stall, so the held write completes in the first unstalled cycle.
- Scoreboard:
  - `preg_ready[p]` is set in the same edge that loads a port register with p (visible in cycle N+1).
  - `preg_ready[p]` is cleared by `alloc_valid` with `alloc_preg == p`.
  - If set and clear target the same p in the same edge, the clear wins.
  - The scoreboard updates even while `stall` is high, but sets only occur for grants, and no grants occur during stall.
- Reset: all `preg_ready` = 1 (initial architectural mapping holds zeros); `rr_ptr` = 0; `update1` = `update2` = 0; indices and data = 0; `req_ready` = 0 while `reset` is high.

## Timing
- Request-to-write-port latency is 1 cycle. Request-to-`preg_ready` latency is 1 cycle. Throughput is 2 writebacks per cycle.
- Worst-case wait for any valid requester is ceil(`NUM_REQ`/2) grant cycles, excluding stall and same-register conflicts.
- Reset asserted mid-stream drops any pending registered write: `update*` = 0 on the next edge. Requesters must re-present their requests.
- `alloc_valid` affects only `preg_ready`, one edge later. It never blocks grants.

## Structure
- Shared package `ooo_pkg`: `NUM_PREG`, `PREG_W`, `DATA_W` constants and a `preg_t` index type, shared with rename and issue.
- Sub-module `rr_pick2`: combinational two-grant rotating picker with the same-register exclusion. Outputs a grant vector and the two port indices.
- Top level holds `rr_ptr`, the write-port registers and the scoreboard.

## Test plan
- Reset, then idle: `preg_ready` = all ones, `update1` = `update2` = 0, `req_ready` = 0.
- Requesters 0 and 2 valid (preg 5 = 0xAAAA, preg 9 = 0xBBBB), `rr_ptr` = 0: `req_ready` = 0101; next cycle port1 = (5, 0xAAAA), port2 = (9, 0xBBBB); `rr_ptr` becomes 3.
- All 4 valid for 3 cycles with distinct pregs: grant order {0,1}, {2,3}, {0,1}; no requester is skipped.
- Requesters 1 and 3 both target preg 7: only 1 is granted; 3 is granted the next cycle; `preg_ready[7]` reads 1 after the first write.
- `stall` high for 2 cycles with requests pending: `req_ready` = 0, port outputs hold the prior write, `rr_ptr` is frozen; normal grants resume after `stall` drops.
- `alloc_valid` with preg 12 in the same cycle a grant for preg 12 is issued: `preg_ready[12]` = 0 next cycle. Mid-stream `reset`: `update*` = 0 next cycle.
